vga_grid_capture: RTL and testbench

// - Receive side of the pong VGA output: consumes hsync/vsync/rrggbb on the 31.5 MHz pixel clock.
// - Rebuilds pixel position from the sync edges and samples the 32x32 cell playfield at cell centres.
// - Once per frame, recovers ball_x/ball_y and both paddle bitmaps.
// - Used as an in-system self-check and as the bench scoreboard for the renderer.

---
 rtl/pong_vga_pkg.sv | 20 ++
 rtl/vga_sync_tracker.sv | 75 +++++++
 rtl/vga_grid_capture.sv | 137 +++++++++++++
 tb/tb_vga_grid_capture.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_vga_pkg.sv
// Shared timing constants and types for the pong VGA capture path.
package pong_vga_pkg;

  localparam logic [9:0] H_START = 10'd128;
  localparam logic [9:0] V_START = 10'd28;
  localparam logic [9:0] H_TOTAL = 10'd832;
  localparam logic [9:0] X_OFF   = 10'd192;
  localparam logic [9:0] Y_OFF   = 10'd112;

  localparam int CELL_SHIFT = 3;
  localparam int GRID_BITS  = 5;

  typedef logic [4:0] cell_t;

  // 10-bit increment that sticks at all-ones
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_sync_tracker.sv
// Registers the VGA inputs once and rebuilds the pixel position from the
// sync deassert edges. Edges are ignored until both input stages hold real
// samples, so a sync already high when reset releases is not seen as an edge.
import pong_vga_pkg::*;

module vga_sync_tracker (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic [5:0] i_rrggbb,
  output logic [9:0] o_px,
  output logic [9:0] o_py,
  output logic       o_lit,
  output logic       o_line_edge,
  output logic       o_frame_start,
  output logic       o_frame_end
);

  logic       r_hs, r_vs, r_hs_d, r_vs_d;
  logic [5:0] r_rgb;
  logic [1:0] r_vld;
  logic [9:0] r_h_cnt, r_v_cnt;
  logic       w_line_edge, w_vs_rise, w_vs_fall;
  logic [9:0] w_h_cnt;

  assign w_line_edge = r_vld[1] & r_hs & ~r_hs_d;
  assign w_vs_rise   = r_vld[1] & r_vs & ~r_vs_d;
  assign w_vs_fall   = r_vld[1] & ~r_vs & r_vs_d;

  // h_cnt reads 0 on the first cycle the registered hsync is high
  assign w_h_cnt = w_line_edge ? 10'd0 : r_h_cnt;

  // input registers, their delayed copies and the sample-valid pipe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hs   <= 1'b0;
      r_vs   <= 1'b0;
      r_hs_d <= 1'b0;
      r_vs_d <= 1'b0;
      r_rgb  <= '0;
      r_vld  <= '0;
    end else begin
      r_hs   <= i_hsync;
      r_vs   <= i_vsync;
      r_hs_d <= r_hs;
      r_vs_d <= r_vs;
      r_rgb  <= i_rrggbb;
      r_vld  <= {r_vld[0], 1'b1};
    end
  end

  // horizontal and vertical position counters; a vsync edge coinciding with
  // a line edge restarts v_cnt and still counts that line
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_h_cnt <= w_line_edge ? 10'd1 : sat_inc10(r_h_cnt);
      if (w_vs_rise)
        r_v_cnt <= w_line_edge ? 10'd1 : 10'd0;
      else if (w_line_edge && r_vs)
        r_v_cnt <= sat_inc10(r_v_cnt);
    end
  end

  assign o_px          = w_h_cnt - H_START;
  assign o_py          = r_v_cnt - V_START;
  assign o_lit         = |r_rgb;
  assign o_line_edge   = w_line_edge;
  assign o_frame_start = w_vs_rise;
  assign o_frame_end   = w_vs_fall;

endmodule

// File: rtl/vga_grid_capture.sv
// Samples the 32x32 pong playfield at cell centres from the VGA stream and
// publishes ball position and paddle bitmaps once per frame.
// Optional build macro CAPTURE_ERR_EN adds a sticky line-length checker.
import pong_vga_pkg::*;

module vga_grid_capture (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [5:0]  rrggbb,
  output logic        frame_valid,
  output logic        ball_found,
  output logic [4:0]  ball_x,
  output logic [4:0]  ball_y,
  output logic [31:0] lpaddle,
  output logic [31:0] rpaddle,
  output logic        locked,
  output logic        timing_err
);

  logic [9:0]  w_px, w_py, w_xr, w_yr;
  logic        w_lit, w_line_edge, w_frame_start, w_frame_end, w_sample;
  cell_t       w_col, w_row;

  logic        r_armed, r_ball_seen;
  cell_t       r_bx_work, r_by_work;
  logic [31:0] r_lp_work, r_rp_work;
  logic        r_frame_valid, r_ball_found, r_locked;
  cell_t       r_ball_x, r_ball_y;
  logic [31:0] r_lpaddle, r_rpaddle;

  vga_sync_tracker u_sync (
    .clk           (clk),
    .reset         (reset),
    .i_hsync       (hsync),
    .i_vsync       (vsync),
    .i_rrggbb      (rrggbb),
    .o_px          (w_px),
    .o_py          (w_py),
    .o_lit         (w_lit),
    .o_line_edge   (w_line_edge),
    .o_frame_start (w_frame_start),
    .o_frame_end   (w_frame_end)
  );

  // offsets into the playfield; anything at or past 256 is outside it
  assign w_xr  = w_px - X_OFF;
  assign w_yr  = w_py - Y_OFF;
  assign w_col = w_xr[CELL_SHIFT +: GRID_BITS];
  assign w_row = w_yr[CELL_SHIFT +: GRID_BITS];
  // the line-restart cycle has px far outside the playfield; gating keeps it inert
  assign w_sample = (w_xr[9:8] == 2'b00) && (w_yr[9:8] == 2'b00) &&
                    (w_xr[2:0] == 3'd4) && (w_yr[2:0] == 3'd4) && !w_line_edge;

  // work registers, frame commit and arming
  always_ff @(posedge clk) begin
    if (reset) begin
      r_armed       <= 1'b0;
      r_ball_seen   <= 1'b0;
      r_bx_work     <= '0;
      r_by_work     <= '0;
      r_lp_work     <= '0;
      r_rp_work     <= '0;
      r_frame_valid <= 1'b0;
      r_ball_found  <= 1'b0;
      r_ball_x      <= '0;
      r_ball_y      <= '0;
      r_lpaddle     <= '0;
      r_rpaddle     <= '0;
      r_locked      <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      if (w_frame_start)
        r_armed <= 1'b1;
      if (w_frame_end) begin
        if (r_armed) begin
          r_frame_valid <= 1'b1;
          r_locked      <= 1'b1;
          r_ball_found  <= r_ball_seen;
          r_ball_x      <= r_bx_work;
          r_ball_y      <= r_by_work;
          r_lpaddle     <= r_lp_work;
          r_rpaddle     <= r_rp_work;
        end
        // an unarmed frame's partial capture is dropped as well
        r_ball_seen <= 1'b0;
        r_bx_work   <= '0;
        r_by_work   <= '0;
        r_lp_work   <= '0;
        r_rp_work   <= '0;
      end else if (w_sample) begin
        if (w_col == 5'd0)
          r_rp_work[w_row] <= w_lit;
        else if (w_col == 5'd31)
          r_lp_work[w_row] <= w_lit;
        else if (w_lit && !r_ball_seen) begin
          r_ball_seen <= 1'b1;
          r_bx_work   <= w_col;
          r_by_work   <= w_row;
        end
      end
    end
  end

`ifdef CAPTURE_ERR_EN
  logic [9:0] r_line_len;
  logic       r_timing_err;

  // r_line_len holds the clocks since the previous line edge when the next one arrives
  always_ff @(posedge clk) begin
    if (reset) begin
      r_line_len   <= '0;
      r_timing_err <= 1'b0;
    end else if (w_line_edge) begin
      r_line_len <= 10'd1;
      if (r_locked && (r_line_len != H_TOTAL))
        r_timing_err <= 1'b1;
    end else begin
      r_line_len <= sat_inc10(r_line_len);
    end
  end

  assign timing_err = r_timing_err;
`else
  assign timing_err = 1'b0;
`endif

  assign frame_valid = r_frame_valid;
  assign ball_found  = r_ball_found;
  assign ball_x      = r_ball_x;
  assign ball_y      = r_ball_y;
  assign lpaddle     = r_lpaddle;
  assign rpaddle     = r_rpaddle;
  assign locked      = r_locked;

endmodule

// File: tb/tb_vga_grid_capture.sv
// Directed bench for vga_grid_capture. Frames are shortened: only lines that
// carry a sample row with lit cells are full 832-clock lines, the rest are
// 8-clock lines, so a frame costs a few thousand clocks.
`timescale 1ns/1ps

module tb_vga_grid_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsync, vsync;
  logic [5:0]  rrggbb;
  logic        frame_valid, ball_found, locked, timing_err;
  logic [4:0]  ball_x, ball_y;
  logic [31:0] lpaddle, rpaddle;

  int checks = 0;
  int failures = 0;

  logic [31:0] t_lp, t_rp;
  int          t_nb;
  int          t_bc[3];
  int          t_br[3];
  bit          t_border;
  int          vcnt;
  int          pulses, first;

  vga_grid_capture dut (
    .clk         (clk),
    .reset       (reset),
    .hsync       (hsync),
    .vsync       (vsync),
    .rrggbb      (rrggbb),
    .frame_valid (frame_valid),
    .ball_found  (ball_found),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .lpaddle     (lpaddle),
    .rpaddle     (rpaddle),
    .locked      (locked),
    .timing_err  (timing_err)
  );

  always #16 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cell_lit(input int c, input int r);
    if (c == 0 && t_rp[r]) return 1'b1;
    if (c == 31 && t_lp[r]) return 1'b1;
    for (int i = 0; i < t_nb; i++)
      if (t_bc[i] == c && t_br[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit pix_lit(input int x, input int y);
    if (x >= 192 && x < 448 && y >= 112 && y < 368)
      return cell_lit((x - 192) / 8, (y - 112) / 8);
    return t_border;
  endfunction

  function automatic bit is_long(input int v);
    int yr;
    yr = v - 28 - 112;
    if (yr < 0 || (yr % 8) != 4) return 1'b0;
    if (t_border) return (yr == 4 || yr == 252 || yr == 260);
    if (yr >= 256) return 1'b0;
    for (int c = 0; c < 32; c++)
      if (cell_lit(c, yr / 8)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_cfg(input logic [31:0] lp, input logic [31:0] rp, input int nb);
    t_lp = lp; t_rp = rp; t_nb = nb; t_border = 1'b0;
  endtask

  // one line: hsync low, then high with pixel k driven k clocks after the rise
  task automatic send_line(input int vline, input bit long_l, input int extra, input int vs_fall_k);
    int low, high;
    low  = long_l ? 96 : 4;
    high = long_l ? 736 + extra : 4;
    hsync = 1'b0; rrggbb = '0;
    repeat (low) @(negedge clk);
    hsync = 1'b1;
    for (int k = 0; k < high; k++) begin
      if (k == vs_fall_k) vsync = 1'b0;
      rrggbb = (long_l && pix_lit(k - 128, vline - 28)) ? 6'($urandom_range(63, 1)) : 6'd0;
      @(negedge clk);
    end
    rrggbb = '0;
  endtask

  task automatic run_lines(input int upto);
    while (vcnt < upto) begin
      vcnt++;
      send_line(vcnt, is_long(vcnt), 0, -1);
    end
  endtask

  task automatic end_frame(output int np, output int fi);
    vsync = 1'b0; np = 0; fi = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (frame_valid === 1'b1) begin
        np++;
        if (fi == 0) fi = i;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic f, input int bx, input int by,
                           input logic [31:0] lp, input logic [31:0] rp);
    check({tag, "_found"}, 32'(ball_found), 32'(f));
    check({tag, "_bx"}, 32'(ball_x), 32'(bx));
    check({tag, "_by"}, 32'(ball_y), 32'(by));
    check({tag, "_lp"}, lpaddle, lp);
    check({tag, "_rp"}, rpaddle, rp);
  endtask

  initial begin
    reset = 1'b1; hsync = 1'b1; vsync = 1'b1; rrggbb = '0;
    set_cfg('0, '0, 0);
    @(negedge clk);
    do_reset();

    // reset state
    check("rst_valid", 32'(frame_valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_terr", 32'(timing_err), 0);
    check_out("rst", 1'b0, 0, 0, '0, '0);

    // first frame after reset: not armed
    set_cfg(32'h0000_0F00, 32'h00F0_0000, 1);
    t_bc[0] = 7; t_br[0] = 12;
    vcnt = 0;
    run_lines(404);
    end_frame(pulses, first);
    check("unarmed_pulses", 32'(pulses), 0);
    check("unarmed_locked", 32'(locked), 0);
    check("unarmed_found", 32'(ball_found), 0);

    // second frame: armed, full capture
    vsync = 1'b1; vcnt = 0;
    run_lines(404);
    end_frame(pulses, first);
    check("ball_pulses", 32'(pulses), 1);
    check("ball_latency", 32'(first), 2);
    check("ball_locked", 32'(locked), 1);
    check_out("ball", 1'b1, 7, 12, 32'h0000_0F00, 32'h00F0_0000);

    // reset mid-frame at line 200
    vsync = 1'b1; vcnt = 0;
    run_lines(200);
    do_reset();
    check("midrst_locked", 32'(locked), 0);
    check("midrst_valid", 32'(frame_valid), 0);
    check_out("midrst", 1'b0, 0, 0, '0, '0);
    set_cfg('0, '0, 0);
    vcnt = 0;
    run_lines(404);
    end_frame(pulses, first);
    check("midrst_pulses", 32'(pulses), 0);
    check("midrst_locked2", 32'(locked), 0);

    // idle frame
    vsync = 1'b1; vcnt = 0;
    run_lines(404);
    end_frame(pulses, first);
    check("idle_pulses", 32'(pulses), 1);
    check("idle_locked", 32'(locked), 1);
    check_out("idle", 1'b0, 0, 0, '0, '0);

    // several lit cells: first in raster order wins
    set_cfg('0, '0, 3);
    t_bc[0] = 3;  t_br[0] = 5;
    t_bc[1] = 20; t_br[1] = 5;
    t_bc[2] = 1;  t_br[2] = 6;
    vsync = 1'b1; vcnt = 0;
    run_lines(404);
    end_frame(pulses, first);
    check("two_pulses", 32'(pulses), 1);
    check_out("two", 1'b1, 3, 5, '0, '0);

    // lit cell only in column 0
    set_cfg('0, 32'h0000_0200, 0);
    vsync = 1'b1; vcnt = 0;
    run_lines(404);
    end_frame(pulses, first);
    check("col0_pulses", 32'(pulses), 1);
    check_out("col0", 1'b0, 0, 0, '0, 32'h0000_0200);

    // corner rows/columns
    set_cfg(32'h8000_0001, 32'h8000_0000, 1);
    t_bc[0] = 30; t_br[0] = 31;
    vsync = 1'b1; vcnt = 0;
    run_lines(404);
    end_frame(pulses, first);
    check("edge_pulses", 32'(pulses), 1);
    check_out("edge", 1'b1, 30, 31, 32'h8000_0001, 32'h8000_0000);

    // everything outside the playfield lit: nothing may be captured
    set_cfg('0, '0, 0);
    t_border = 1'b1;
    vsync = 1'b1; vcnt = 0;
    run_lines(404);
    end_frame(pulses, first);
    check("border_pulses", 32'(pulses), 1);
    check_out("border", 1'b0, 0, 0, '0, '0);
    t_border = 1'b0;

`ifdef CAPTURE_ERR_EN
    do_reset();
    check("terr_rst", 32'(timing_err), 0);
    vsync = 1'b1;
    send_line(0, 1'b1, 0, -1);
    send_line(0, 1'b1, 0, -1);
    send_line(0, 1'b1, 0, 100);
    repeat (3) send_line(0, 1'b1, 0, -1);
    check("terr_locked", 32'(locked), 1);
    check("terr_ok", 32'(timing_err), 0);
    send_line(0, 1'b1, 1, -1);
    send_line(0, 1'b1, 0, -1);
    check("terr_set", 32'(timing_err), 1);
    repeat (2) send_line(0, 1'b1, 0, -1);
    check("terr_sticky", 32'(timing_err), 1);
    do_reset();
    check("terr_clear", 32'(timing_err), 0);
`else
    check("terr_tied", 32'(timing_err), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
